// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: per-operand forwarding mux, load-use bubble insertion,
// ID/EX pipeline latch with hold/flush handling and saturating event counters.
module id_ex_operand_stage #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [AW-1:0]     id_rs,
    input  logic [AW-1:0]     id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [AW-1:0]     id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [DW-1:0]     id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DW-1:0]     rf_rd1,
    input  logic [DW-1:0]     rf_rd2,
    input  logic [DW-1:0]     ex_result,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic [AW-1:0]     mem_dst,
    input  logic [DW-1:0]     mem_result,
    input  logic              wb_regwrite,
    input  logic [AW-1:0]     wb_dst,
    input  logic [DW-1:0]     wb_data,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [AW-1:0]     ex_dst,
    output logic [DW-1:0]     ex_a,
    output logic [DW-1:0]     ex_b,
    output logic [DW-1:0]     ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    logic              ex_valid_q, ex_valid_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q, ex_memread_d;
    logic [AW-1:0]     ex_dst_q, ex_dst_d;
    logic [DW-1:0]     ex_a_q, ex_a_d;
    logic [DW-1:0]     ex_b_q, ex_b_d;
    logic [DW-1:0]     ex_imm_q, ex_imm_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic [15:0]       flush_cnt_q, flush_cnt_d;
    logic              pend_flush_q, pend_flush_d;

    logic [DW-1:0]     op_a;
    logic [DW-1:0]     op_b;
    logic              lu;
    logic              eff_flush;

    // Youngest producer wins; a load in EX has no data yet, so it never forwards.
    function automatic logic [DW-1:0] sel_operand(input logic [AW-1:0] idx,
                                                  input logic [DW-1:0] rf_val);
        if (idx == '0)
            return '0;
        if (ex_valid_q && ex_regwrite_q && !ex_memread_q && ex_dst_q == idx)
            return ex_result;
        if (mem_valid && mem_regwrite && mem_dst == idx)
            return mem_result;
        if (wb_regwrite && wb_dst == idx)
            return wb_data;
        return rf_val;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign op_a = sel_operand(id_rs, rf_rd1);
    assign op_b = sel_operand(id_rt, rf_rd2);

    assign lu = id_valid && ex_valid_q && ex_memread_q && ex_regwrite_q &&
                (ex_dst_q != '0) &&
                ((id_use_rs && ex_dst_q == id_rs) || (id_use_rt && ex_dst_q == id_rt));

    assign eff_flush = flush || pend_flush_q;
    assign stall_id  = !rst && (ex_hold || (lu && !flush && !pend_flush_q));

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memread_d  = ex_memread_q;
        ex_dst_d      = ex_dst_q;
        ex_a_d        = ex_a_q;
        ex_b_d        = ex_b_q;
        ex_imm_d      = ex_imm_q;
        ex_ctrl_d     = ex_ctrl_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        pend_flush_d  = pend_flush_q;

        if (ex_hold) begin
            // A flush seen while frozen must still kill the ID instruction later.
            if (flush)
                pend_flush_d = 1'b1;
        end else if (eff_flush) begin
            ex_valid_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
            pend_flush_d  = 1'b0;
            flush_cnt_d   = sat_inc(flush_cnt_q);
        end else if (lu) begin
            ex_valid_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
            stall_cnt_d   = sat_inc(stall_cnt_q);
        end else begin
            ex_valid_d    = id_valid;
            ex_regwrite_d = id_regwrite && id_valid;
            ex_memread_d  = id_memread && id_valid;
            ex_dst_d      = id_dst;
            ex_a_d        = op_a;
            ex_b_d        = op_b;
            ex_imm_d      = id_imm;
            ex_ctrl_d     = id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_dst_q      <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_imm_q      <= '0;
            ex_ctrl_q     <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            pend_flush_q  <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_dst_q      <= ex_dst_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_imm_q      <= ex_imm_d;
            ex_ctrl_q     <= ex_ctrl_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            pend_flush_q  <= pend_flush_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memread  = ex_memread_q;
    assign ex_dst      = ex_dst_q;
    assign ex_a        = ex_a_q;
    assign ex_b        = ex_b_q;
    assign ex_imm      = ex_imm_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: forwarding table plus hand-written
// load-use, flush, hold and counter saturation sequences.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic [31:0] id_imm;
    logic [11:0] id_ctrl;
    logic [31:0] rf_rd1, rf_rd2, ex_result, mem_result, wb_data;
    logic        mem_valid, mem_regwrite, wb_regwrite;
    logic [4:0]  mem_dst, wb_dst;
    logic        ex_hold, flush;
    logic        stall_id, ex_valid, ex_regwrite, ex_memread;
    logic [4:0]  ex_dst;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [11:0] ex_ctrl;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.DW(32), .AW(5), .CTRL_W(12)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
        .mem_result(mem_result), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst),
        .wb_data(wb_data), .ex_hold(ex_hold), .flush(flush), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_dst(ex_dst), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic [4:0]  pre_dst;
        logic        pre_rw, pre_ld;
        logic [4:0]  rs, rt;
        logic        use_rs, use_rt;
        logic [31:0] rf1, rf2, exr;
        logic        mv, mrw;
        logic [4:0]  mdst;
        logic [31:0] memr;
        logic        wrw;
        logic [4:0]  wdst;
        logic [31:0] wbd;
        logic        e_stall, e_valid;
        logic [31:0] e_a, e_b;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_dst = 0; id_regwrite = 0; id_memread = 0; id_imm = 0; id_ctrl = 0;
        rf_rd1 = 0; rf_rd2 = 0; ex_result = 0;
        mem_valid = 0; mem_regwrite = 0; mem_dst = 0; mem_result = 0;
        wb_regwrite = 0; wb_dst = 0; wb_data = 0;
        ex_hold = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        #1;
        chk("stall_in_reset", {31'd0, stall_id}, 32'd0);
        step();
        rst = 0;
    endtask

    // Puts an instruction into the EX latch without touching any source register.
    task automatic load_ex(input logic [4:0] dst, input logic rw, input logic ld);
        idle();
        id_valid = 1; id_dst = dst; id_regwrite = rw; id_memread = ld;
        step();
    endtask

    initial begin
        rst = 1;
        idle();
        vt[0]  = '{5'd9, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 32'd5,  32'd7,  32'h0,
                   1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 32'd5,  32'd7};
        vt[1]  = '{5'd3, 1'b1, 1'b0, 5'd3, 5'd2, 1'b1, 1'b1, 32'd1,  32'd7,  32'hAA,
                   1'b1, 1'b1, 5'd3, 32'hBB, 1'b1, 5'd3, 32'hCC, 1'b0, 1'b1, 32'hAA, 32'd7};
        vt[2]  = '{5'd8, 1'b1, 1'b0, 5'd3, 5'd2, 1'b1, 1'b1, 32'd1,  32'd7,  32'hAA,
                   1'b1, 1'b1, 5'd3, 32'hBB, 1'b1, 5'd3, 32'hCC, 1'b0, 1'b1, 32'hBB, 32'd7};
        vt[3]  = '{5'd8, 1'b1, 1'b0, 5'd3, 5'd2, 1'b1, 1'b1, 32'd1,  32'd7,  32'hAA,
                   1'b0, 1'b1, 5'd3, 32'hBB, 1'b1, 5'd3, 32'hCC, 1'b0, 1'b1, 32'hCC, 32'd7};
        vt[4]  = '{5'd0, 1'b1, 1'b0, 5'd0, 5'd2, 1'b1, 1'b1, 32'h55, 32'd7,  32'hAA,
                   1'b1, 1'b1, 5'd0, 32'hBB, 1'b1, 5'd0, 32'hCC, 1'b0, 1'b1, 32'h0,  32'd7};
        vt[5]  = '{5'd3, 1'b1, 1'b0, 5'd1, 5'd3, 1'b1, 1'b1, 32'd5,  32'd9,  32'hAA,
                   1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 32'd5,  32'hAA};
        vt[6]  = '{5'd4, 1'b1, 1'b1, 5'd4, 5'd2, 1'b0, 1'b0, 32'h11, 32'd7,  32'hAA,
                   1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 32'h11, 32'd7};
        vt[7]  = '{5'd3, 1'b0, 1'b0, 5'd3, 5'd2, 1'b1, 1'b1, 32'h21, 32'd7,  32'hAA,
                   1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 32'h21, 32'd7};
        vt[8]  = '{5'd4, 1'b1, 1'b1, 5'd1, 5'd4, 1'b1, 1'b1, 32'd5,  32'd9,  32'hAA,
                   1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0};
        vt[9]  = '{5'd0, 1'b1, 1'b1, 5'd0, 5'd2, 1'b1, 1'b1, 32'd5,  32'd7,  32'hAA,
                   1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 32'h0,  32'd7};
        vt[10] = '{5'd9, 1'b1, 1'b0, 5'd1, 5'd6, 1'b1, 1'b1, 32'd5,  32'd9,  32'hAA,
                   1'b1, 1'b1, 5'd1, 32'h31, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1, 32'h31, 32'h66};

        // Reset state
        do_reset();
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_a", ex_a, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);

        // Forwarding / hazard table
        for (int i = 0; i < 11; i++) begin
            load_ex(vt[i].pre_dst, vt[i].pre_rw, vt[i].pre_ld);
            idle();
            id_valid = 1; id_rs = vt[i].rs; id_rt = vt[i].rt;
            id_use_rs = vt[i].use_rs; id_use_rt = vt[i].use_rt;
            rf_rd1 = vt[i].rf1; rf_rd2 = vt[i].rf2; ex_result = vt[i].exr;
            mem_valid = vt[i].mv; mem_regwrite = vt[i].mrw; mem_dst = vt[i].mdst;
            mem_result = vt[i].memr; wb_regwrite = vt[i].wrw; wb_dst = vt[i].wdst;
            wb_data = vt[i].wbd;
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, stall_id}, {31'd0, vt[i].e_stall});
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vt[i].e_valid});
            if (vt[i].e_valid) begin
                chk($sformatf("v%0d_a", i), ex_a, vt[i].e_a);
                chk($sformatf("v%0d_b", i), ex_b, vt[i].e_b);
            end
        end

        // Load-use: one bubble, then MEM forwards the load data
        do_reset();
        load_ex(5'd4, 1'b1, 1'b1);
        idle();
        id_valid = 1; id_rs = 4; id_use_rs = 1; rf_rd1 = 32'hDEAD;
        #1;
        chk("lu_stall", {31'd0, stall_id}, 32'd1);
        step();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        mem_valid = 1; mem_regwrite = 1; mem_dst = 4; mem_result = 32'h1234;
        #1;
        chk("lu_stall_released", {31'd0, stall_id}, 32'd0);
        step();
        chk("lu_capture_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_capture_a", ex_a, 32'h1234);
        chk("lu_stall_cnt_after", {16'd0, stall_cnt}, 32'd1);

        // Flush during load-use: flush wins
        do_reset();
        load_ex(5'd4, 1'b1, 1'b1);
        idle();
        id_valid = 1; id_rs = 4; id_use_rs = 1; flush = 1;
        #1;
        chk("flu_stall", {31'd0, stall_id}, 32'd0);
        step();
        chk("flu_valid", {31'd0, ex_valid}, 32'd0);
        chk("flu_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        chk("flu_stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // Hold with flush pulsed in the middle
        do_reset();
        idle();
        id_valid = 1; id_rs = 1; id_rt = 2; id_use_rs = 1; id_use_rt = 1;
        rf_rd1 = 32'h77; rf_rd2 = 32'h88; id_dst = 5; id_regwrite = 1;
        id_imm = 32'hFFFF_FFF0; id_ctrl = 12'hA5C;
        step();
        chk("cap_dst", {27'd0, ex_dst}, 32'd5);
        chk("cap_rw", {31'd0, ex_regwrite}, 32'd1);
        chk("cap_imm", ex_imm, 32'hFFFF_FFF0);
        chk("cap_ctrl", {20'd0, ex_ctrl}, 32'hA5C);
        rf_rd1 = 32'h99; id_imm = 32'h3; id_ctrl = 12'h001; id_dst = 7;
        ex_hold = 1;
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1);
            #1;
            chk($sformatf("hold%0d_stall", c), {31'd0, stall_id}, 32'd1);
            step();
            chk($sformatf("hold%0d_valid", c), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("hold%0d_a", c), ex_a, 32'h77);
            chk($sformatf("hold%0d_ctrl", c), {20'd0, ex_ctrl}, 32'hA5C);
        end
        ex_hold = 0; flush = 0;
        step();
        chk("posthold_valid", {31'd0, ex_valid}, 32'd0);
        chk("posthold_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        step();
        chk("posthold_recapture", {31'd0, ex_valid}, 32'd1);
        chk("posthold_a", ex_a, 32'h99);
        chk("posthold_flush_cnt2", {16'd0, flush_cnt}, 32'd1);

        // Self-dependent load alternates capture and bubble
        do_reset();
        idle();
        id_valid = 1; id_rs = 4; id_use_rs = 1; id_dst = 4; id_regwrite = 1; id_memread = 1;
        for (int c = 0; c < 10; c++) step();
        chk("alt_stall_cnt", {16'd0, stall_cnt}, 32'd5);

        // Flush counter saturation
        do_reset();
        flush = 1;
        for (int c = 0; c < 65540; c++) step();
        flush = 0;
        chk("flush_cnt_sat", {16'd0, flush_cnt}, 32'hFFFF);
        step();
        chk("flush_cnt_sat_hold", {16'd0, flush_cnt}, 32'hFFFF);

        // Reset mid-hold drops the pending flush
        idle();
        id_valid = 1; id_rs = 1; rf_rd1 = 32'h42; id_dst = 3; id_regwrite = 1;
        step();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        ex_hold = 1; flush = 1;
        step();
        flush = 0; rst = 1;
        #1;
        chk("rst_hold_stall", {31'd0, stall_id}, 32'd0);
        step();
        rst = 0;
        chk("rst2_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst2_a", ex_a, 32'd0);
        chk("rst2_dst", {27'd0, ex_dst}, 32'd0);
        chk("rst2_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        chk("rst2_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        ex_hold = 0;
        step();
        chk("rst2_no_pend_valid", {31'd0, ex_valid}, 32'd1);
        chk("rst2_no_pend_cnt", {16'd0, flush_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute operand stage, directly downstream of the 2R/1W register file read ports (RD1/RD2).
- Selects each source operand from one of: the register file, the WB write data, the MEM result, or the EX result (forwarding).
- Detects load-use hazards and inserts bubbles.
- Registers the result into the ID/EX pipeline latch, with hold and flush handling.

Parameters:
- DW, 32, datapath width
- AW, 5, register index width
- CTRL_W, 12, opaque EX/MEM/WB control bundle width

Ports:
- clk  in  1  clock; every state element updates on posedge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  AW  source register indices (also drive RF A1/A2)
- id_use_rs, id_use_rt  in  1  instruction actually reads rs/rt
- id_dst  in  AW  destination register index
- id_regwrite, id_memread  in  1  instruction writes a register / is a load
- id_imm  in  DW  extended immediate
- id_ctrl  in  CTRL_W  control bundle, passed through
- rf_rd1, rf_rd2  in  DW  register file read data
- ex_result  in  DW  combinational ALU result of the instruction now in EX
- mem_valid, mem_regwrite  in  1  MEM-stage instruction status
- mem_dst  in  AW  MEM-stage destination register
- mem_result  in  DW  MEM-stage final value (load data or ALU result)
- wb_regwrite  in  1  WB-stage write enable (same as RF RegWrite)
- wb_dst  in  AW  WB-stage destination (same as RF A3)
- wb_data  in  DW  WB-stage data (same as RF WD3)
- ex_hold  in  1  EX stage busy; freeze the latch
- flush  in  1  wrong-path kill of the ID instruction
- stall_id  out  1  hold PC and IF/ID this cycle
- ex_valid, ex_regwrite, ex_memread  out  1  latch contents
- ex_dst  out  AW  latch contents
- ex_a, ex_b, ex_imm  out  DW  latch contents
- ex_ctrl  out  CTRL_W  latch contents
- stall_cnt, flush_cnt  out  16  saturating performance counters

Behaviour:
- Reset: every ex_* output, stall_cnt, flush_cnt and pend_flush go to 0. stall_id is 0 during reset.
- Operand select (combinational, evaluated per operand for idx = rs or rt), first match wins:
  - idx==0 gives 0.
  - EX match: ex_valid & ex_regwrite & !ex_memread & ex_dst==idx gives ex_result.
  - MEM match: mem_valid & mem_regwrite & mem_dst==idx gives mem_result.
  - WB match: wb_regwrite & wb_dst==idx gives wb_data. The RF writes only at posedge, so a same-cycle read still returns the old value.
  - Otherwise the rf_rd value.
- Load-use hazard (lu) = id_valid & ex_valid & ex_memread & ex_regwrite & ex_dst!=0 & ((id_use_rs & ex_dst==id_rs) | (id_use_rt & ex_dst==id_rt)).
- stall_id = !rst & (ex_hold | (lu & !flush & !pend_flush)).
- Register update at posedge, priority order:
  1. rst.
  2. ex_hold=1: all ex_* registers hold. If flush=1, set pend_flush.
  3. Effective flush (flush | pend_flush): ex_valid<=0, ex_regwrite<=0, ex_memread<=0, pend_flush<=0. Other fields are don't-care.
  4. lu: insert a bubble (same clearing as flush). The ID instruction is re-evaluated next cycle.
  5. Otherwise capture: ex_valid<=id_valid, ex_regwrite<=id_regwrite&id_valid, ex_memread<=id_memread&id_valid, and the selected operands, id_imm, id_ctrl, id_dst.
- Latency: 1 cycle from ID to the ex_* outputs. A load-use pair adds exactly 1 bubble; the following capture gets the load data via the MEM match.
- Counters:
  - stall_cnt +1 on each edge where lu caused a bubble (case 4).
  - flush_cnt +1 on each edge where case 3 applied.
  - Both saturate at 16'hFFFF; no wrap-around.
  - Neither counter increments during hold.
- Flush arriving while lu is active: the flush wins, no stall is raised, and only flush_cnt increments.
- rst asserted mid-hold or mid-stall: state clears on that edge, and pend_flush is dropped.

Test Plan:
- Plain capture: rs=1, rt=2, rf_rd1=5, rf_rd2=7, no hazards → next edge ex_valid=1, ex_a=5, ex_b=7, stall_id stays 0.
- Forward priority: rs=3 with EX (ALU) dst=3 result 0xAA, MEM dst=3 result 0xBB, WB dst=3 data 0xCC → ex_a=0xAA. Remove the EX match → 0xBB. Remove the MEM match → 0xCC. Set rs=0 with all matches present → ex_a=0.
- Load-use: EX holds a load with dst=4, ID uses rs=4 → stall_id=1 for one cycle, ex_valid=0 next edge, stall_cnt=1. On the following edge the MEM match supplies 0x1234 → ex_a=0x1234.
- Flush during load-use: same as the load-use case plus flush=1 → stall_id=0, ex_valid=0, flush_cnt=1, stall_cnt=0.
- Hold with flush: ex_hold=1 for 3 cycles, flush pulsed in cycle 2 → ex_* unchanged through the hold, stall_id=1. First edge after the hold gives ex_valid=0 and flush_cnt=1.
- Saturation and reset: force 70000 load-use bubbles → stall_cnt=0xFFFF. Then rst for 1 cycle mid-hold → all outputs 0 and pend_flush cleared.
